// File: rtl/decode_stage_if.sv
// Handshake and decoded-field bundle between fetch, the decode stage and execute.
// The slave modport is the decode stage's view; master is the surrounding pipeline's view.
interface decode_stage_if #(
    parameter int unsigned IW   = 8,
    parameter int unsigned OPW  = 3,
    parameter int unsigned RDW  = 2,
    parameter int unsigned SRCW = 3,
    parameter int unsigned DW   = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [IW-1:0]   in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [OPW-1:0]  out_opcode;
    logic [RDW-1:0]  out_rd;
    logic [SRCW-1:0] out_src;
    logic [DW-1:0]   out_imm;
    logic            out_long;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_opcode, out_rd, out_src, out_imm, out_long
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_opcode, out_rd, out_src, out_imm, out_long
    );
endinterface

// File: rtl/decode_stage.sv
// Registered valid/ready instruction decode stage with optional short-immediate sign
// extension and a two-word long-immediate form introduced by EXT_OPCODE.
module decode_stage #(
    parameter int unsigned   IW         = 8,
    parameter int unsigned   OPW        = 3,
    parameter int unsigned   RDW        = 2,
    parameter int unsigned   SRCW       = 3,
    parameter int unsigned   DW         = 8,
    parameter logic [OPW-1:0] EXT_OPCODE = OPW'(3'b111),
    parameter bit            SIGN_EXT   = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    decode_stage_if.slave  bus
);

    typedef enum logic {S_FIRST, S_EXT} state_e;

    state_e          state_q, state_d;
    logic [OPW-1:0]  pend_op_q, pend_op_d;
    logic [RDW-1:0]  pend_rd_q, pend_rd_d;
    logic [SRCW-1:0] pend_src_q, pend_src_d;

    logic            out_valid_q, out_valid_d;
    logic [OPW-1:0]  out_op_q, out_op_d;
    logic [RDW-1:0]  out_rd_q, out_rd_d;
    logic [SRCW-1:0] out_src_q, out_src_d;
    logic [DW-1:0]   out_imm_q, out_imm_d;
    logic            out_long_q, out_long_d;

    logic [OPW-1:0]  f_op;
    logic [RDW-1:0]  f_rd;
    logic [SRCW-1:0] f_src;
    logic [DW-1:0]   short_imm;
    logic            in_ready_c;
    logic            accept;
    logic            load;

    assign f_op  = bus.in_instr[IW-1 -: OPW];
    assign f_rd  = bus.in_instr[SRCW +: RDW];
    assign f_src = bus.in_instr[SRCW-1:0];

    // Short immediate widened to DW, sign- or zero-extended by build option
    always_comb begin
        short_imm = DW'(f_src);
        if (SIGN_EXT) begin
            short_imm = {{(DW-SRCW){f_src[SRCW-1]}}, f_src};
        end
    end

    assign in_ready_c = rst_n && !flush && (!out_valid_q || bus.out_ready);
    assign accept     = bus.in_valid && in_ready_c;

    // Next-state and output-register load decisions
    always_comb begin
        state_d     = state_q;
        pend_op_d   = pend_op_q;
        pend_rd_d   = pend_rd_q;
        pend_src_d  = pend_src_q;
        out_op_d    = out_op_q;
        out_rd_d    = out_rd_q;
        out_src_d   = out_src_q;
        out_imm_d   = out_imm_q;
        out_long_d  = out_long_q;
        out_valid_d = out_valid_q;
        load        = 1'b0;

        if (flush) begin
            state_d     = S_FIRST;
            pend_op_d   = '0;
            pend_rd_d   = '0;
            pend_src_d  = '0;
            out_valid_d = 1'b0;
        end else begin
            if (accept) begin
                unique case (state_q)
                    S_FIRST: begin
                        if (f_op == EXT_OPCODE) begin
                            pend_op_d  = f_op;
                            pend_rd_d  = f_rd;
                            pend_src_d = f_src;
                            state_d    = S_EXT;
                        end else begin
                            load       = 1'b1;
                            out_op_d   = f_op;
                            out_rd_d   = f_rd;
                            out_src_d  = f_src;
                            out_imm_d  = short_imm;
                            out_long_d = 1'b0;
                        end
                    end
                    S_EXT: begin
                        // Second word is pure immediate data, never an opcode
                        load       = 1'b1;
                        out_op_d   = pend_op_q;
                        out_rd_d   = pend_rd_q;
                        out_src_d  = pend_src_q;
                        out_imm_d  = DW'(bus.in_instr);
                        out_long_d = 1'b1;
                        state_d    = S_FIRST;
                    end
                    default: state_d = S_FIRST;
                endcase
            end

            if (load) begin
                out_valid_d = 1'b1;
            end else if (bus.out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State and pipeline registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_FIRST;
            pend_op_q   <= '0;
            pend_rd_q   <= '0;
            pend_src_q  <= '0;
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_rd_q    <= '0;
            out_src_q   <= '0;
            out_imm_q   <= '0;
            out_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_op_q   <= pend_op_d;
            pend_rd_q   <= pend_rd_d;
            pend_src_q  <= pend_src_d;
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_rd_q    <= out_rd_d;
            out_src_q   <= out_src_d;
            out_imm_q   <= out_imm_d;
            out_long_q  <= out_long_d;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_opcode = out_op_q;
    assign bus.out_rd     = out_rd_q;
    assign bus.out_src    = out_src_q;
    assign bus.out_imm    = out_imm_q;
    assign bus.out_long   = out_long_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: three builds (zero-ext DW=8, sign-ext DW=8, sign-ext DW=16)
// share one stimulus stream and are checked against an instruction-level model.
module tb_decode_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_instr;
    logic       out_ready;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    always #5 clk = ~clk;

    decode_stage_if #(.DW(8))  if0 ();
    decode_stage_if #(.DW(8))  if1 ();
    decode_stage_if #(.DW(16)) if2 ();

    assign if0.in_valid = in_valid;  assign if0.in_instr = in_instr;  assign if0.out_ready = out_ready;
    assign if1.in_valid = in_valid;  assign if1.in_instr = in_instr;  assign if1.out_ready = out_ready;
    assign if2.in_valid = in_valid;  assign if2.in_instr = in_instr;  assign if2.out_ready = out_ready;

    decode_stage #(.DW(8),  .SIGN_EXT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if0));
    decode_stage #(.DW(8),  .SIGN_EXT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if1));
    decode_stage #(.DW(16), .SIGN_EXT(1'b1)) dut2 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Instruction-level model: one held output slot plus an optional pending first word
    bit          m_started = 1'b0;
    bit          m_valid, m_rstz, m_have_first, m_long;
    int unsigned m_op, m_rd, m_src, m_imm_z8, m_imm_s8, m_imm_s16;
    int unsigned m_first;

    always @(posedge clk) begin
        bit          acc;
        bit          loaded;
        int unsigned w;
        int          s;
        if (!rst_n) begin
            m_started = 1'b1;
            m_valid = 1'b0; m_have_first = 1'b0; m_rstz = 1'b1;
            m_op = 0; m_rd = 0; m_src = 0; m_long = 1'b0;
            m_imm_z8 = 0; m_imm_s8 = 0; m_imm_s16 = 0;
        end else if (m_started) begin
            if (flush) begin
                m_valid = 1'b0; m_have_first = 1'b0; m_rstz = 1'b0;
            end else begin
                w      = int'(in_instr);
                acc    = in_valid && (!m_valid || out_ready);
                loaded = 1'b0;
                if (acc) begin
                    if (m_have_first) begin
                        m_op = m_first / 32; m_rd = (m_first / 8) % 4; m_src = m_first % 8;
                        m_imm_z8 = w; m_imm_s8 = w; m_imm_s16 = w;
                        m_long = 1'b1; m_have_first = 1'b0; loaded = 1'b1;
                    end else if (w / 32 == 7) begin
                        m_first = w; m_have_first = 1'b1;
                    end else begin
                        m_op = w / 32; m_rd = (w / 8) % 4; m_src = w % 8;
                        s = (m_src >= 4) ? int'(m_src) - 8 : int'(m_src);
                        m_imm_z8  = m_src;
                        m_imm_s8  = unsigned'(s) % 256;
                        m_imm_s16 = unsigned'(s) % 65536;
                        m_long = 1'b0; loaded = 1'b1;
                    end
                end
                if (loaded) begin
                    m_valid = 1'b1; m_rstz = 1'b0;
                end else if (out_ready) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison of all three builds against the model
    always @(negedge clk) begin
        logic exp_rdy;
        if (m_started) begin
            exp_rdy = rst_n && !flush && (!m_valid || out_ready);
            chk("in_ready0", 32'(if0.in_ready), 32'(exp_rdy));
            chk("in_ready1", 32'(if1.in_ready), 32'(exp_rdy));
            chk("in_ready2", 32'(if2.in_ready), 32'(exp_rdy));
            chk("out_valid0", 32'(if0.out_valid), 32'(m_valid));
            chk("out_valid1", 32'(if1.out_valid), 32'(m_valid));
            chk("out_valid2", 32'(if2.out_valid), 32'(m_valid));
            if (m_valid || m_rstz) begin
                chk("opcode", 32'(if0.out_opcode), m_op);
                chk("rd",     32'(if0.out_rd),     m_rd);
                chk("src",    32'(if0.out_src),    m_src);
                chk("long0",  32'(if0.out_long),   32'(m_long));
                chk("long2",  32'(if2.out_long),   32'(m_long));
                chk("opcode2", 32'(if2.out_opcode), m_op);
                chk("imm_z8",  32'(if0.out_imm), m_imm_z8);
                chk("imm_s8",  32'(if1.out_imm), m_imm_s8);
                chk("imm_s16", 32'(if2.out_imm), m_imm_s16);
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] w, input logic r,
                        input logic f, input logic rn);
        in_valid = v; in_instr = w; out_ready = r; flush = f; rst_n = rn;
        @(posedge clk);
        #1;
    endtask

    // Hand-computed expectations sampled just after the edge
    task automatic lit(input string nm, input int unsigned op, input int unsigned rd,
                       input int unsigned src, input int unsigned i0, input int unsigned i1,
                       input int unsigned i2, input logic lng);
        chk({nm, ".valid"},  32'(if0.out_valid),  32'd1);
        chk({nm, ".opcode"}, 32'(if0.out_opcode), op);
        chk({nm, ".rd"},     32'(if0.out_rd),     rd);
        chk({nm, ".src"},    32'(if0.out_src),    src);
        chk({nm, ".imm0"},   32'(if0.out_imm),    i0);
        chk({nm, ".imm1"},   32'(if1.out_imm),    i1);
        chk({nm, ".imm2"},   32'(if2.out_imm),    i2);
        chk({nm, ".long"},   32'(if1.out_long),   32'(lng));
    endtask

    initial begin
        in_valid = 1'b1; in_instr = 8'h4D; out_ready = 1'b1; flush = 1'b0; rst_n = 1'b0;
        step(1, 8'h4D, 1, 0, 0);
        step(1, 8'h4D, 1, 0, 0);
        chk("reset.valid", 32'(if2.out_valid), 32'd0);
        chk("reset.imm",   32'(if2.out_imm),   32'd0);

        // Short decode and drain
        step(1, 8'h4D, 1, 0, 1);
        lit("short4D", 2, 1, 5, 32'h05, 32'hFD, 32'hFFFD, 1'b0);
        step(0, 8'h00, 1, 0, 1);
        chk("drain.valid", 32'(if0.out_valid), 32'd0);
        step(1, 8'h4B, 1, 0, 1);
        lit("short4B", 2, 1, 3, 32'h03, 32'h03, 32'h0003, 1'b0);

        // Long immediate pair
        step(1, 8'hE6, 1, 0, 1);
        chk("long.first_hidden", 32'(if0.out_valid), 32'd0);
        step(1, 8'h9C, 1, 0, 1);
        lit("long9C", 7, 0, 6, 32'h9C, 32'h9C, 32'h009C, 1'b1);

        // Backpressure then release and a back-to-back stream
        step(1, 8'h4D, 1, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 8'h21, 0, 0, 1);
        lit("held4D", 2, 1, 5, 32'h05, 32'hFD, 32'hFFFD, 1'b0);
        step(1, 8'h21, 1, 0, 1);
        lit("short21", 1, 0, 1, 32'h01, 32'h01, 32'h0001, 1'b0);
        step(1, 8'h4B, 1, 0, 1);
        step(1, 8'h6F, 1, 0, 1);
        lit("short6F", 3, 1, 7, 32'h07, 32'hFF, 32'hFFFF, 1'b0);
        step(1, 8'h00, 1, 0, 1);
        step(0, 8'h00, 1, 0, 1);

        // Flush while a long instruction is half captured
        step(1, 8'hE6, 1, 0, 1);
        step(1, 8'h4D, 1, 1, 1);
        chk("flush.valid", 32'(if0.out_valid), 32'd0);
        step(1, 8'h4D, 1, 0, 1);
        lit("postflush", 2, 1, 5, 32'h05, 32'hFD, 32'hFFFD, 1'b0);

        // First word of a long pair while the slot drains
        step(1, 8'hE6, 1, 0, 1);
        chk("extdrain.valid", 32'(if0.out_valid), 32'd0);
        step(1, 8'h9C, 1, 0, 1);
        lit("long9C_b", 7, 0, 6, 32'h9C, 32'h9C, 32'h009C, 1'b1);

        // Reset while in the middle of a long pair
        step(1, 8'hE6, 1, 0, 1);
        step(1, 8'h9C, 1, 0, 0);
        chk("midrst.valid", 32'(if1.out_valid), 32'd0);
        chk("midrst.opcode", 32'(if1.out_opcode), 32'd0);
        step(1, 8'h9C, 1, 0, 1);
        lit("post_rst9C", 4, 3, 4, 32'h04, 32'hFC, 32'hFFFC, 1'b0);

        // Mixed traffic with random backpressure and occasional flush
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0), 1'b1);
        end
        step(0, 8'h00, 1, 0, 1);
        step(0, 8'h00, 1, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
